ddr_byte_port: RTL and testbench
================================

Name: ddr_byte_port

Overview:
- Byte-wide responder between the 8-bit loader/sound initiators and the 64-bit DDRAM Avalon interface.
- Serves two kinds of requests on one shared port:
  - HPS download writes (ioctl bytes).
  - Wave-sound DMA reads.
- Keeps a one-word (64-bit) read cache, so sequential byte reads mostly complete without DDRAM traffic.
- Drives the DDRAM_* pins of emu directly; the initiator holds ioctl_wait while O_READY is low.

Parameters:
- DDR_BASE, 4'h3, DDRAM_ADDR[28:25] for every access (selects the 256 MB window).
- BURST, 8'd1, DDRAM_BURSTCNT for reads without the optional feature.

Ports:
- I_CLK  in  1  system clock (clk_sys); also forwarded to DDRAM_CLK.
- I_RSTn  in  1  asynchronous active-low reset.
- I_ADDR  in  28  byte address.
- I_DIN  in  8  write byte.
- I_WE  in  1  write request, sampled only when O_READY=1.
- I_RD  in  1  read request, sampled only when O_READY=1.
- O_DOUT  out  8  read byte, valid while O_READY=1 after a read.
- O_READY  out  1  port idle / previous request complete.
- DDRAM_CLK  out  1  equals I_CLK.
- DDRAM_BUSY  in  1  Avalon waitrequest.
- DDRAM_BURSTCNT  out  8  burst length.
- DDRAM_ADDR  out  29  {DDR_BASE, I_ADDR[27:3]}.
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read data valid.
- DDRAM_RD  out  1  read command.
- DDRAM_DIN  out  64  write data; the byte is replicated to all 8 lanes.
- DDRAM_BE  out  8  one-hot lane, 1<<I_ADDR[2:0].
- DDRAM_WE  out  1  write command.

Behaviour:
- Reset values:
  - O_READY=1, O_DOUT=0.
  - DDRAM_RD=0, DDRAM_WE=0, DDRAM_BE=0, DDRAM_DIN=0.
  - DDRAM_ADDR={DDR_BASE,25'd0}, DDRAM_BURSTCNT=BURST.
  - Cache invalid; state IDLE.
- State machine IDLE, WR_CMD, RD_CMD, RD_WAIT, HIT.
- Requests are accepted only in IDLE with O_READY=1. Acceptance latches the address and data, and O_READY falls on the next edge.
- I_WE and I_RD both high: the write wins and the read is dropped. The initiator must re-issue the read.
- Write path:
  - IDLE -> WR_CMD; assert DDRAM_WE, ADDR, BE and DIN.
  - Hold all of them until a cycle with DDRAM_BUSY=0. On that edge, deassert WE and go to IDLE with O_READY=1.
  - If the write address hits the cached word, update the cached lane in the same cycle, so the cache never goes stale.
- Read hit (cache valid and tag == I_ADDR[27:3]):
  - IDLE -> HIT; O_DOUT=lane[I_ADDR[2:0]].
  - O_READY returns high 2 edges after acceptance. No DDRAM access.
- Read miss:
  - IDLE -> RD_CMD; DDRAM_RD held until BUSY=0, then RD_WAIT.
  - On the first DDRAM_DOUT_READY: store the word, set tag and valid, drive O_DOUT with the selected lane, O_READY=1, go to IDLE.
- Lane select: byte n = DDRAM_DOUT[8n+7:8n] (little-endian).
- DDRAM_DOUT_READY outside RD_WAIT (e.g. after a mid-read reset) is ignored.
- Reset mid-operation clears state, invalidates the cache and drops commands immediately. Late DDRAM data is discarded.
- Address wrap: I_ADDR=28'hFFFFFFF maps to word 25'h1FFFFFF. There is no carry into DDR_BASE.

Optional Feature:
- Macro DDR_BYTE_PREFETCH_EN.
- When defined:
  - Misses issue DDRAM_BURSTCNT=2.
  - Beat 0 fills line A; beat 1 fills line B with tag+1.
  - O_READY rises on beat 0, but a new request is not accepted until beat 1 has landed.
  - A hit in either line completes in 2 edges. Writes update whichever line matches.
- Without the macro: single-line cache, BURSTCNT=BURST, and line B logic is absent.

Decomposition:
- Package ddr_byte_pkg holds:
  - state_t enum (IDLE, WR_CMD, RD_CMD, RD_WAIT, HIT).
  - DDR_WORD_W=64, ADDR_W=28.
  - A lane_select function.
- One natural sub-module, ddr_line_cache: tag/valid/data storage, hit compare and lane write-merge, instantiated once (twice with prefetch).

Test Plan:
- Write 8'hA5 to 28'h0000013 with BUSY low -> one WE cycle: ADDR={4'h3,25'h2}, BE=8'h08, DIN=64'hA5A5A5A5A5A5A5A5; O_READY high 2 edges after acceptance.
- Read 28'h10 (miss), DDRAM returns 64'h8877665544332211 after 5 cycles -> one RD with BURSTCNT=1, O_DOUT=8'h11; then reads 0x11..0x17 give 22..88 with no DDRAM_RD, each ready 2 edges after acceptance.
- Hold BUSY high 4 cycles during a read miss -> DDRAM_RD and ADDR stable all 4 cycles, with exactly one command accepted.
- After the cached read of 0x10, write 8'hFF to 0x12, then read 0x12 -> O_DOUT=8'hFF without DDRAM_RD.
- Assert I_RSTn low during RD_WAIT, then pulse DOUT_READY -> outputs at reset values, cache invalid, data ignored; the next read of 0x10 issues a fresh RD.
- With DDR_BYTE_PREFETCH_EN: read miss 0x20 -> BURSTCNT=2; subsequent reads 0x20..0x2F trigger no further DDRAM_RD.

Source files
------------

// File: rtl/ddr_byte_pkg.sv
// ddr_byte_pkg: shared widths, FSM states and the byte-lane helper for ddr_byte_port.
package ddr_byte_pkg;
    localparam int DDR_WORD_W = 64;
    localparam int ADDR_W = 28;
    localparam int TAG_W = ADDR_W - 3;

    typedef enum logic [2:0] {IDLE, WR_CMD, RD_CMD, RD_WAIT, HIT} state_t;

    // Little-endian lane pick: byte n lives in bits [8n+7:8n].
    function automatic logic [7:0] lane_select(input logic [DDR_WORD_W-1:0] word, input logic [2:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/ddr_byte_port_if.sv
// ddr_byte_port_if: byte initiator request/response plus the DDRAM Avalon pins.
interface ddr_byte_port_if;
    import ddr_byte_pkg::*;
    logic [ADDR_W-1:0] I_ADDR;
    logic [7:0] I_DIN;
    logic I_WE;
    logic I_RD;
    logic [7:0] O_DOUT;
    logic O_READY;
    logic DDRAM_CLK;
    logic DDRAM_BUSY;
    logic [7:0] DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [DDR_WORD_W-1:0] DDRAM_DOUT;
    logic DDRAM_DOUT_READY;
    logic DDRAM_RD;
    logic [DDR_WORD_W-1:0] DDRAM_DIN;
    logic [7:0] DDRAM_BE;
    logic DDRAM_WE;

    modport master (
        output I_ADDR, I_DIN, I_WE, I_RD, DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input O_DOUT, O_READY, DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );
    modport slave (
        input I_ADDR, I_DIN, I_WE, I_RD, DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output O_DOUT, O_READY, DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );
endinterface

// File: rtl/ddr_line_cache.sv
// ddr_line_cache: one 64-bit cached DDRAM word with tag/valid, hit compare and byte write-merge.
module ddr_line_cache
    import ddr_byte_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fill,
    input  logic [TAG_W-1:0]      i_fill_tag,
    input  logic [DDR_WORD_W-1:0] i_fill_data,
    input  logic                  i_wr,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [7:0]            i_wr_byte,
    output logic                  o_hit,
    output logic [DDR_WORD_W-1:0] o_word
);
    logic r_valid;
    logic [TAG_W-1:0] r_tag;
    logic [DDR_WORD_W-1:0] r_data;

    assign o_hit = r_valid && r_tag == i_addr[ADDR_W-1:3];
    assign o_word = r_data;

    // Fill and write never coincide: fills only happen while the port is busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_tag <= '0;
            r_data <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag <= i_fill_tag;
            r_data <= i_fill_data;
        end else if (i_wr && o_hit) begin
            r_data[{i_addr[2:0], 3'b000} +: 8] <= i_wr_byte;
        end
    end
endmodule

// File: rtl/ddr_byte_port.sv
// ddr_byte_port: byte-wide responder onto the 64-bit DDRAM port with a read cache.
// Optional DDR_BYTE_PREFETCH_EN: two-beat miss bursts filling a second line with the next word.
module ddr_byte_port
    import ddr_byte_pkg::*;
#(
    parameter logic [3:0] DDR_BASE = 4'h3,
    parameter logic [7:0] BURST = 8'd1
) (
    input logic I_CLK,
    input logic I_RSTn,
    ddr_byte_port_if.slave bus
);
    state_t r_state, w_state;
    logic r_ready, w_ready;
    logic [7:0] r_dout, w_dout;
    logic r_rd, w_rd;
    logic r_we, w_we;
    logic [7:0] r_be, w_be;
    logic [DDR_WORD_W-1:0] r_din, w_din;
    logic [28:0] r_addr, w_addr;
    logic [2:0] r_lane, w_lane;
    logic w_wr_req, w_rd_req;
    logic w_hit_a, w_hit, w_fill_a;
    logic [DDR_WORD_W-1:0] w_word_a, w_hit_word;

    assign w_wr_req = r_state == IDLE && r_ready && bus.I_WE;
    assign w_rd_req = r_state == IDLE && r_ready && bus.I_RD && !bus.I_WE;

    ddr_line_cache u_line_a (
        .i_clk(I_CLK),
        .i_rst_n(I_RSTn),
        .i_fill(w_fill_a),
        .i_fill_tag(r_addr[TAG_W-1:0]),
        .i_fill_data(bus.DDRAM_DOUT),
        .i_wr(w_wr_req),
        .i_addr(bus.I_ADDR),
        .i_wr_byte(bus.I_DIN),
        .o_hit(w_hit_a),
        .o_word(w_word_a)
    );

`ifdef DDR_BYTE_PREFETCH_EN
    logic r_beat, w_beat;
    logic w_hit_b, w_fill_b;
    logic [DDR_WORD_W-1:0] w_word_b;

    ddr_line_cache u_line_b (
        .i_clk(I_CLK),
        .i_rst_n(I_RSTn),
        .i_fill(w_fill_b),
        .i_fill_tag(r_addr[TAG_W-1:0] + TAG_W'(1)),
        .i_fill_data(bus.DDRAM_DOUT),
        .i_wr(w_wr_req),
        .i_addr(bus.I_ADDR),
        .i_wr_byte(bus.I_DIN),
        .o_hit(w_hit_b),
        .o_word(w_word_b)
    );

    assign w_fill_a = r_state == RD_WAIT && bus.DDRAM_DOUT_READY && !r_beat;
    assign w_fill_b = r_state == RD_WAIT && bus.DDRAM_DOUT_READY && r_beat;
    assign w_hit = w_hit_a || w_hit_b;
    assign w_hit_word = w_hit_a ? w_word_a : w_word_b;
    assign bus.DDRAM_BURSTCNT = 8'd2;
`else
    assign w_fill_a = r_state == RD_WAIT && bus.DDRAM_DOUT_READY;
    assign w_hit = w_hit_a;
    assign w_hit_word = w_word_a;
    assign bus.DDRAM_BURSTCNT = BURST;
`endif

    always_comb begin
        w_state = r_state;
        w_ready = r_ready;
        w_dout = r_dout;
        w_rd = r_rd;
        w_we = r_we;
        w_be = r_be;
        w_din = r_din;
        w_addr = r_addr;
        w_lane = r_lane;
`ifdef DDR_BYTE_PREFETCH_EN
        w_beat = r_beat;
`endif
        case (r_state)
            IDLE: begin
                if (w_wr_req) begin
                    w_state = WR_CMD;
                    w_ready = 1'b0;
                    w_we = 1'b1;
                    w_addr = {DDR_BASE, bus.I_ADDR[ADDR_W-1:3]};
                    w_be = 8'd1 << bus.I_ADDR[2:0];
                    w_din = {8{bus.I_DIN}};
                end else if (w_rd_req) begin
                    w_ready = 1'b0;
                    w_lane = bus.I_ADDR[2:0];
                    w_state = w_hit ? HIT : RD_CMD;
                    w_rd = !w_hit;
                    w_dout = w_hit ? lane_select(w_hit_word, bus.I_ADDR[2:0]) : r_dout;
                    w_addr = w_hit ? r_addr : {DDR_BASE, bus.I_ADDR[ADDR_W-1:3]};
                end
            end
            WR_CMD: begin
                if (!bus.DDRAM_BUSY) begin
                    w_we = 1'b0;
                    w_ready = 1'b1;
                    w_state = IDLE;
                end
            end
            RD_CMD: begin
                if (!bus.DDRAM_BUSY) begin
                    w_rd = 1'b0;
                    w_state = RD_WAIT;
                end
            end
            RD_WAIT: begin
`ifdef DDR_BYTE_PREFETCH_EN
                // Beat 0 answers the initiator; stay here so nothing is accepted before beat 1.
                if (bus.DDRAM_DOUT_READY && !r_beat) begin
                    w_dout = lane_select(bus.DDRAM_DOUT, r_lane);
                    w_ready = 1'b1;
                    w_beat = 1'b1;
                end else if (bus.DDRAM_DOUT_READY) begin
                    w_beat = 1'b0;
                    w_state = IDLE;
                end
`else
                if (bus.DDRAM_DOUT_READY) begin
                    w_dout = lane_select(bus.DDRAM_DOUT, r_lane);
                    w_ready = 1'b1;
                    w_state = IDLE;
                end
`endif
            end
            HIT: begin
                w_ready = 1'b1;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_dout <= '0;
            r_rd <= 1'b0;
            r_we <= 1'b0;
            r_be <= '0;
            r_din <= '0;
            r_addr <= {DDR_BASE, {TAG_W{1'b0}}};
            r_lane <= '0;
`ifdef DDR_BYTE_PREFETCH_EN
            r_beat <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_ready <= w_ready;
            r_dout <= w_dout;
            r_rd <= w_rd;
            r_we <= w_we;
            r_be <= w_be;
            r_din <= w_din;
            r_addr <= w_addr;
            r_lane <= w_lane;
`ifdef DDR_BYTE_PREFETCH_EN
            r_beat <= w_beat;
`endif
        end
    end

    assign bus.DDRAM_CLK = I_CLK;
    assign bus.O_READY = r_ready;
    assign bus.O_DOUT = r_dout;
    assign bus.DDRAM_RD = r_rd;
    assign bus.DDRAM_WE = r_we;
    assign bus.DDRAM_BE = r_be;
    assign bus.DDRAM_DIN = r_din;
    assign bus.DDRAM_ADDR = r_addr;
endmodule

// File: tb/tb_ddr_byte_port.sv
// tb_ddr_byte_port: random and directed byte traffic against a byte-memory reference and a DDRAM responder.
module tb_ddr_byte_port;
    import ddr_byte_pkg::*;
`ifdef DDR_BYTE_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    localparam logic [7:0] EXP_BURST = PF ? 8'd2 : 8'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    ddr_byte_port_if bus();
    ddr_byte_port dut (.I_CLK(clk), .I_RSTn(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: untouched bytes follow a fixed address hash.
    function automatic logic [7:0] init_byte(input logic [27:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ {4'h0, a[27:24]} ^ 8'h5A;
    endfunction

    logic [63:0] ddr_mem [logic [24:0]];
    logic [63:0] beat_q[$];
    int lat = 1;
    int cnt = 0;
    int rd_cmds = 0;
    int we_cmds = 0;
    bit busy_force = 1'b0;
    bit rnd_busy = 1'b0;
    logic [28:0] last_addr = '0;
    logic [7:0] last_be = '0;
    logic [63:0] last_din = '0;

    function automatic logic [63:0] mem_word(input logic [24:0] w);
        logic [63:0] v;
        if (ddr_mem.exists(w)) return ddr_mem[w];
        for (int i = 0; i < 8; i++) v[8*i +: 8] = init_byte({w, i[2:0]});
        return v;
    endfunction

    // DDRAM responder: counts accepted commands, applies writes, returns read beats after lat cycles.
    initial begin
        logic [24:0] rw;
        logic [63:0] rv;
        bus.DDRAM_BUSY = 1'b0;
        bus.DDRAM_DOUT_READY = 1'b0;
        bus.DDRAM_DOUT = '0;
        forever begin
            @(posedge clk);
            if (rst_n && bus.DDRAM_RD && !bus.DDRAM_BUSY) begin
                rd_cmds++;
                rw = bus.DDRAM_ADDR[24:0];
                chk("burstcnt", bus.DDRAM_BURSTCNT, EXP_BURST);
                for (int b = 0; b < int'(bus.DDRAM_BURSTCNT) && b < 4; b++) beat_q.push_back(mem_word(rw + 25'(b)));
                cnt = lat;
            end
            if (rst_n && bus.DDRAM_WE && !bus.DDRAM_BUSY) begin
                we_cmds++;
                last_addr = bus.DDRAM_ADDR;
                last_be = bus.DDRAM_BE;
                last_din = bus.DDRAM_DIN;
                rw = bus.DDRAM_ADDR[24:0];
                rv = mem_word(rw);
                for (int i = 0; i < 8; i++) if (bus.DDRAM_BE[i]) rv[8*i +: 8] = bus.DDRAM_DIN[8*i +: 8];
                ddr_mem[rw] = rv;
            end
            @(negedge clk);
            bus.DDRAM_BUSY = busy_force || (rnd_busy && $urandom_range(3) == 0);
            if (beat_q.size() > 0 && cnt > 0) cnt--;
            if (beat_q.size() > 0 && cnt == 0) begin
                bus.DDRAM_DOUT_READY = 1'b1;
                bus.DDRAM_DOUT = beat_q.pop_front();
            end else begin
                bus.DDRAM_DOUT_READY = 1'b0;
                bus.DDRAM_DOUT = {$urandom, $urandom};
            end
        end
    end

    // Reference: plain byte memory plus the set of words the port should currently hold.
    logic [7:0] ref_mem [logic [27:0]];
    bit m_valid = 1'b0;
    logic [24:0] m_tag_a = '0;
    logic [24:0] m_tag_b = '0;

    function automatic logic [7:0] ref_byte(input logic [27:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic bit model_miss(input logic [24:0] w);
        return !(m_valid && (m_tag_a == w || (PF && m_tag_b == w)));
    endfunction

    task automatic wait_idle();
        int k = 0;
        while ((!bus.O_READY || beat_q.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", 64'(k < 300), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_reset();
        chk("rst_ready", bus.O_READY, 1);
        chk("rst_dout", bus.O_DOUT, 0);
        chk("rst_rd", bus.DDRAM_RD, 0);
        chk("rst_we", bus.DDRAM_WE, 0);
        chk("rst_be", bus.DDRAM_BE, 0);
        chk("rst_din", bus.DDRAM_DIN, 0);
        chk("rst_addr", bus.DDRAM_ADDR, {4'h3, 25'd0});
        chk("rst_burst", bus.DDRAM_BURSTCNT, EXP_BURST);
    endtask

    task automatic do_write(input logic [27:0] a, input logic [7:0] d, input bit both, input bit chk_lat);
        int n, rc0, wc0;
        wait_idle();
        rc0 = rd_cmds;
        wc0 = we_cmds;
        bus.I_ADDR = a;
        bus.I_DIN = d;
        bus.I_WE = 1'b1;
        bus.I_RD = both;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        bus.I_WE = 1'b0;
        bus.I_RD = 1'b0;
        chk("wr_busy", bus.O_READY, 0);
        while (!bus.O_READY && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("wr_done", bus.O_READY, 1);
        if (chk_lat) chk("wr_lat", n, 2);
        chk("wr_cmds", we_cmds - wc0, 1);
        chk("wr_no_rd", rd_cmds - rc0, 0);
        chk("wr_addr", last_addr, {4'h3, a[27:3]});
        chk("wr_be", last_be, 8'd1 << a[2:0]);
        chk("wr_din", last_din, {8{d}});
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [27:0] a, input int hold);
        int n, rc0;
        bit miss;
        logic [24:0] w;
        logic [7:0] exp;
        wait_idle();
        w = a[27:3];
        miss = model_miss(w);
        exp = ref_byte(a);
        rc0 = rd_cmds;
        if (hold > 0) begin
            busy_force = 1'b1;
            @(negedge clk);
        end
        bus.I_ADDR = a;
        bus.I_RD = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        bus.I_RD = 1'b0;
        chk("rd_busy", bus.O_READY, 0);
        for (int i = 0; i < hold; i++) begin
            chk("hold_rd", bus.DDRAM_RD, 1);
            chk("hold_addr", bus.DDRAM_ADDR, {4'h3, w});
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        busy_force = 1'b0;
        while (!bus.O_READY && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("rd_done", bus.O_READY, 1);
        chk("rd_data", bus.O_DOUT, exp);
        chk("rd_cmds", rd_cmds - rc0, 64'(miss));
        if (!miss) chk("hit_lat", n, 2);
        if (miss) begin
            m_valid = 1'b1;
            m_tag_a = w;
            m_tag_b = w + 25'd1;
        end
    endtask

    initial begin
        int k, rc0;
        logic [27:0] ra;
        bus.I_ADDR = '0;
        bus.I_DIN = '0;
        bus.I_WE = 1'b0;
        bus.I_RD = 1'b0;
        ddr_mem[25'h2] = 64'h8877665544332211;
        for (int i = 0; i < 8; i++) ref_mem[28'h10 + 28'(i)] = 8'(8'h11 * (i + 1));
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        @(negedge clk);

        do_write(28'h13, 8'hA5, 1'b0, 1'b1);
        lat = 5;
        do_read(28'h10, 0);
        lat = 2;
        for (int i = 1; i < 8; i++) do_read(28'h10 + 28'(i), 0);
        do_write(28'h12, 8'hFF, 1'b0, 1'b1);
        do_read(28'h12, 0);
        do_read(28'h40, 4);

        // Reset while the port waits for read data; the late beat must be ignored.
        wait_idle();
        rc0 = rd_cmds;
        lat = 20;
        bus.I_ADDR = 28'h80;
        bus.I_RD = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.I_RD = 1'b0;
        k = 0;
        while (rd_cmds == rc0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rst_cmd", rd_cmds - rc0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset();
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (beat_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk("late_ready", bus.O_READY, 1);
        chk("late_dout", bus.O_DOUT, 0);
        chk("late_rd", bus.DDRAM_RD, 0);
        lat = 2;
        do_read(28'h10, 0);

        do_write(28'hFFFFFFF, 8'h3C, 1'b0, 1'b1);
        do_read(28'hFFFFFFF, 0);
        do_write(28'h41, 8'h77, 1'b1, 1'b1);
        do_read(28'h41, 0);
        for (int i = 0; i < 16; i++) do_read(28'h20 + 28'(i), 0);

        rnd_busy = 1'b1;
        repeat (300) begin
            ra = 28'($urandom_range(255));
            lat = $urandom_range(6, 1);
            if ($urandom_range(2) == 0) do_write(ra, 8'($urandom), 1'($urandom_range(1)), 1'b0);
            else do_read(ra, 0);
        end
        rnd_busy = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
